// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: state encoding and default width.
package serial_adder_pkg;
  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;
endpackage

// File: rtl/full_adder.sv
// One-bit combinational full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell plus a carry flop, LSB first,
// result and carry-out registered with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d, res_q, res_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, busy_q, busy_d, done_q, done_d;
  logic             fa_sum, fa_carry;
  logic [WIDTH-1:0] res_shifted;

  full_adder u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .c    (carry_q),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  // New bit enters at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  assign res_shifted = {fa_sum, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          sa_d    = a;
          sb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          res_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        res_d   = res_shifted;
        carry_d = fa_carry;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sum_d   = res_shifted;
          cout_d  = fa_carry;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed 8-bit vectors plus an exhaustive 4-bit sweep.
module tb_serial_adder;
  typedef struct {
    logic [32:0] res;
    int          acc;
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  logic       start4, cin4, busy4, done4, cout4;
  logic [3:0] a4, b4, sum4;

  exp_t q8[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   blen8 = 0;
  int   blen4 = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  // Monitor: samples 1 time unit after each rising edge and retires scoreboard entries.
  initial forever begin
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    if (!rst_n) begin
      blen8 = 0;
      blen4 = 0;
    end else begin
      if (busy8) blen8++;
      else if (blen8 != 0) begin
        checks++;
        if (blen8 != 8) begin
          errors++;
          $display("FAIL busy8_len actual=%0d required=8", blen8);
        end
        blen8 = 0;
      end
      if (busy4) blen4++;
      else if (blen4 != 0) begin
        checks++;
        if (blen4 != 4) begin
          errors++;
          $display("FAIL busy4_len actual=%0d required=4", blen4);
        end
        blen4 = 0;
      end
      if (done8) begin
        checks++;
        if (busy8) begin
          errors++;
          $display("FAIL busy8_with_done actual=1 required=0");
        end
        if (q8.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done8_unexpected actual sum=%h cout=%b required no done", sum8, cout8);
        end else begin
          e = q8.pop_front();
          checks += 2;
          $display("txn w8 %h+%h+%b -> cout=%b sum=%h (expect %h) at edge %0d",
                   e.a[7:0], e.b[7:0], e.c, cout8, sum8, e.res[8:0], cyc - e.acc);
          if ({cout8, sum8} !== e.res[8:0]) begin
            errors++;
            $display("FAIL result8 actual=%h required=%h", {cout8, sum8}, e.res[8:0]);
          end
          // done is seen right after edge E0+WIDTH
          if (cyc - e.acc != 8) begin
            errors++;
            $display("FAIL latency8 actual=%0d required=8", cyc - e.acc);
          end
        end
      end
      if (done4) begin
        checks++;
        if (busy4) begin
          errors++;
          $display("FAIL busy4_with_done actual=1 required=0");
        end
        if (q4.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done4_unexpected actual sum=%h cout=%b required no done", sum4, cout4);
        end else begin
          e = q4.pop_front();
          checks += 2;
          $display("txn w4 %h+%h+%b -> cout=%b sum=%h (expect %h) at edge %0d",
                   e.a[3:0], e.b[3:0], e.c, cout4, sum4, e.res[4:0], cyc - e.acc);
          if ({cout4, sum4} !== e.res[4:0]) begin
            errors++;
            $display("FAIL result4 actual=%h required=%h", {cout4, sum4}, e.res[4:0]);
          end
          if (cyc - e.acc != 4) begin
            errors++;
            $display("FAIL latency4 actual=%0d required=4", cyc - e.acc);
          end
        end
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    @(negedge clk);
    while ((busy8 || done8) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL idle8_timeout actual busy=%b done=%b required idle", busy8, done8);
    end
  endtask

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] exp);
    exp_t e;
    wait_idle8();
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    e.res = 33'(exp); e.acc = cyc + 1; e.a = 32'(a); e.b = 32'(b); e.c = c;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
  endtask

  task automatic pulse8(input logic [7:0] a, input logic [7:0] b);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [4:0] exp);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while ((busy4 || done4) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL idle4_timeout actual busy=%b done=%b required idle", busy4, done4);
    end
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    e.res = 33'(exp); e.acc = cyc + 1; e.a = 32'(a); e.b = 32'(b); e.c = c;
    q4.push_back(e);
    @(negedge clk);
    start4 = 1'b0; a4 = ~a; b4 = ~b; cin4 = ~c;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 8) ? q8.size() : q4.size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL drain%0d_timeout actual pending=%0d required=0", which,
               (which == 8) ? q8.size() : q4.size());
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    checks += 2;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL reset8 actual=%h required=0", {busy8, done8, cout8, sum8});
    end
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      errors++;
      $display("FAIL reset4 actual=%h required=0", {busy4, done4, cout4, sum4});
    end
    rst_n = 1'b1;

    issue8(8'h00, 8'h00, 1'b0, 9'h000);
    issue8(8'hFF, 8'h01, 1'b0, 9'h100);
    issue8(8'hA5, 8'h5A, 1'b1, 9'h100);
    issue8(8'h3C, 8'h42, 1'b0, 9'h07E);

    // Second start while RUN must be ignored.
    issue8(8'h10, 8'h20, 1'b0, 9'h030);
    repeat (2) @(negedge clk);
    pulse8(8'hFF, 8'hFF);

    // Start during the done cycle must be ignored as well.
    n = 0;
    while (!done8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!done8) begin
      errors++;
      $display("FAIL done_wait actual done=%b required=1", done8);
    end
    pulse8(8'h77, 8'h11);
    checks++;
    if (busy8 !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done_ignored actual busy=%b required=0", busy8);
    end
    issue8(8'h3C, 8'h42, 1'b0, 9'h07E);
    drain(8);

    // Reset in the middle of a run.
    issue8(8'hF0, 8'h0F, 1'b0, 9'h0FF);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, cout8, sum8} !== 11'd0) begin
      errors++;
      $display("FAIL midrun_reset actual=%h required=0", {busy8, done8, cout8, sum8});
    end
    void'(q8.pop_back());
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if ({busy8, done8} !== 2'b00) begin
      errors++;
      $display("FAIL resume_after_reset actual busy/done=%b required=00", {busy8, done8});
    end
    issue8(8'h01, 8'h02, 1'b0, 9'h003);
    drain(8);

    // Exhaustive 4-bit sweep.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < 2; k++)
          issue4(4'(i), 4'(j), 1'(k), 5'(i + j + k));
    drain(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
